// File: rtl/anc_delay_pkg.sv
// anc_delay_pkg: shared sample type, default sizes and select-width helper for the ANC delay line
package anc_delay_pkg;

    localparam int ANC_SAMPLE_W          = 32;
    localparam int ANC_DELAY_MAX_DEFAULT = 16;

    typedef logic signed [ANC_SAMPLE_W-1:0] anc_sample_t;

    function automatic int anc_sel_w(input int max_depth);
        return $clog2(max_depth + 1);
    endfunction

endpackage

// File: rtl/anc_delay_stage.sv
// anc_delay_stage: one sample register with async reset, sync clear and shift enable
module anc_delay_stage
    import anc_delay_pkg::*;
#(
    parameter int WIDTH = ANC_SAMPLE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d, data_q;

    // clear beats enable so a flush drops a coincident sample
    always_comb data_d = clr ? '0 : en ? d : data_q;

    // sample register
    always_ff @(posedge clk or posedge rst)
        if (rst) data_q <= '0;
        else     data_q <= data_d;

    assign q = data_q;

endmodule

// File: rtl/anc_delay_line.sv
// anc_delay_line: runtime-selectable 0..MAX_DEPTH sample delay with primed tracking and flush
// Define ANC_DELAY_TAPS_EN to expose every storage register on taps_flat.
module anc_delay_line
    import anc_delay_pkg::*;
#(
    parameter int WIDTH     = ANC_SAMPLE_W,
    parameter int MAX_DEPTH = ANC_DELAY_MAX_DEFAULT,
    parameter int SEL_W     = anc_sel_w(MAX_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        delay_sel,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0]        fill_cnt,
`ifdef ANC_DELAY_TAPS_EN
    output logic                    sel_err,
    output logic [MAX_DEPTH*WIDTH-1:0] taps_flat
`else
    output logic                    sel_err
`endif
);

    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DEPTH);

    logic [WIDTH-1:0] sr [MAX_DEPTH];
    logic [WIDTH-1:0] tap, out_data_d, out_data_q;
    logic [SEL_W-1:0] eff_sel, fill_cnt_d, fill_cnt_q;
    logic             over, out_valid_d, out_valid_q, sel_err_d, sel_err_q;

    for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            anc_delay_stage #(.WIDTH(WIDTH)) u_stage (
                .clk(clk), .rst(rst), .clr(flush), .en(in_valid), .d(in_data), .q(sr[k])
            );
        end else begin : g_tail
            anc_delay_stage #(.WIDTH(WIDTH)) u_stage (
                .clk(clk), .rst(rst), .clr(flush), .en(in_valid), .d(sr[k-1]), .q(sr[k])
            );
        end
`ifdef ANC_DELAY_TAPS_EN
        assign taps_flat[k*WIDTH +: WIDTH] = sr[k];
`endif
    end

    // pick the pre-shift tap for the clamped delay; zero delay passes the input straight through
    always_comb begin
        over = delay_sel > MAX_SEL;
        eff_sel = over ? MAX_SEL : delay_sel;
        tap = in_data;
        for (int k = 0; k < MAX_DEPTH; k++)
            if (eff_sel == SEL_W'(k + 1)) tap = sr[k];
    end

    // next output, fill level and error flag; flush wins over a coincident strobe
    always_comb begin
        out_data_d  = flush ? '0 : in_valid ? tap : out_data_q;
        out_valid_d = !flush && in_valid && (fill_cnt_q >= eff_sel);
        fill_cnt_d  = flush ? '0 : (in_valid && fill_cnt_q != MAX_SEL) ? fill_cnt_q + SEL_W'(1) : fill_cnt_q;
        sel_err_d   = sel_err_q | over;
    end

    // output and bookkeeping registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            fill_cnt_q  <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            fill_cnt_q  <= fill_cnt_d;
            sel_err_q   <= sel_err_d;
        end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign fill_cnt  = fill_cnt_q;
    assign sel_err   = sel_err_q;

endmodule
